// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: shared state encoding and flash constants for the SPI flash arbiter.
package spi_flash_pkg;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, GAP} state_t;
  localparam logic [7:0] CMD_READ = 8'h03;
  localparam int FLASH_ADDR_W = 24;
endpackage

// File: rtl/spi_shift_engine.sv
// spi_shift_engine: SCK divider plus a 32-bit MSB-first transmit shifter and an 8-bit receive shifter.
module spi_shift_engine #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        shift_en,
  input  logic [31:0] load_data,
  input  logic        spi_so,
  output logic        data_clk,
  output logic        spi_si,
  output logic        bit_done,
  output logic        byte_done,
  output logic        fall,
  output logic [7:0]  rx_byte
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [DW-1:0] div_q, div_d;
  logic          sck_q, sck_d, bit_done_q, bit_done_d, byte_done_q, byte_done_d;
  logic [31:0]   sr_q, sr_d;
  logic [7:0]    rx_q, rx_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic          tick, rise;
  assign tick = shift_en && div_q == DW'(CLK_DIV - 1);
  assign rise = tick && !sck_q;
  assign fall = tick && sck_q;
  // MISO is captured on the same clk edge that raises SCK; MOSI advances with each falling edge
  always_comb begin
    div_d       = (load || !shift_en || tick) ? '0 : div_q + DW'(1);
    sck_d       = (load || !shift_en) ? 1'b0 : tick ? !sck_q : sck_q;
    sr_d        = load ? load_data : fall ? {sr_q[30:0], 1'b0} : sr_q;
    rx_d        = rise ? {rx_q[6:0], spi_so} : rx_q;
    bcnt_d      = load ? 3'd0 : rise ? bcnt_q + 3'd1 : bcnt_q;
    bit_done_d  = rise;
    byte_done_d = rise && bcnt_q == 3'd7;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      div_q       <= '0;
      sck_q       <= 1'b0;
      sr_q        <= '0;
      rx_q        <= '0;
      bcnt_q      <= '0;
      bit_done_q  <= 1'b0;
      byte_done_q <= 1'b0;
    end else begin
      div_q       <= div_d;
      sck_q       <= sck_d;
      sr_q        <= sr_d;
      rx_q        <= rx_d;
      bcnt_q      <= bcnt_d;
      bit_done_q  <= bit_done_d;
      byte_done_q <= byte_done_d;
    end
  assign data_clk  = sck_q;
  assign spi_si    = sr_q[31];
  assign bit_done  = bit_done_q;
  assign byte_done = byte_done_q;
  assign rx_byte   = rx_q;
endmodule

// File: rtl/spi_flash_arbiter.sv
// spi_flash_arbiter: round-robin sharing of a read-only SPI flash between boot loader (port 0)
// and disk streamer (port 1); each grant runs one 0x03 read of N bytes.
module spi_flash_arbiter
  import spi_flash_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              req,
  input  logic [FLASH_ADDR_W-1:0] addr0,
  input  logic [FLASH_ADDR_W-1:0] addr1,
  input  logic [7:0]              len0,
  input  logic [7:0]              len1,
  output logic [1:0]              gnt,
  output logic                    rd_valid,
  output logic [7:0]              rd_data,
  output logic [1:0]              done,
  output logic                    chip_select,
  output logic                    data_clk,
  output logic                    spi_si,
  input  logic                    spi_so
);
  localparam int GW = $clog2(CS_GAP + 1);
  state_t        state_q, state_d;
  logic          owner_q, owner_d, last_owner_q, last_owner_d, cs_q, cs_d;
  logic          rd_valid_q, rd_valid_d, pick, load, shift_en;
  logic          bit_done, byte_done, fall;
  logic [8:0]    byte_cnt_q, byte_cnt_d;
  logic [5:0]    bit_cnt_q, bit_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [1:0]    gnt_q, gnt_d, done_q, done_d;
  logic [7:0]    rd_data_q, rd_data_d, rx_byte, len_sel;
  logic [31:0]   load_data;
  assign pick      = &req ? !last_owner_q : req[1];
  assign len_sel   = pick ? len1 : len0;
  assign load_data = {CMD_READ, pick ? addr1 : addr0};
  assign shift_en  = state_q inside {CMD, ADDR, DATA};
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    byte_cnt_d   = byte_cnt_q;
    bit_cnt_d    = bit_done ? bit_cnt_q + 6'd1 : bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    gnt_d        = gnt_q;
    done_d       = 2'b00;
    cs_d         = cs_q;
    rd_valid_d   = 1'b0;
    rd_data_d    = rd_data_q;
    load         = 1'b0;
    case (state_q)
      IDLE: if (|req) begin
        state_d      = CMD;
        owner_d      = pick;
        last_owner_d = pick;
        byte_cnt_d   = {len_sel == 8'd0, len_sel};
        bit_cnt_d    = '0;
        gnt_d        = pick ? 2'b10 : 2'b01;
        cs_d         = 1'b0;
        load         = 1'b1;
      end
      CMD:  if (bit_done && bit_cnt_q == 6'd7) state_d = ADDR;
      ADDR: if (bit_done && bit_cnt_q == 6'd31) state_d = DATA;
      DATA: begin
        if (byte_done) begin
          byte_cnt_d = byte_cnt_q - 9'd1;
          rd_valid_d = 1'b1;
          rd_data_d  = rx_byte;
        end
        // leave on the falling SCK edge that follows the last sampled bit
        if (byte_cnt_d == 9'd0 && fall) begin
          state_d   = GAP;
          cs_d      = 1'b1;
          done_d    = owner_q ? 2'b10 : 2'b01;
          gap_cnt_d = GW'(CS_GAP - 1);
        end
      end
      GAP: begin
        gnt_d = 2'b00;
        if (gap_cnt_q == '0) state_d = IDLE;
        else gap_cnt_d = gap_cnt_q - GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      byte_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      gnt_q        <= 2'b00;
      done_q       <= 2'b00;
      cs_q         <= 1'b1;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      byte_cnt_q   <= byte_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      cs_q         <= cs_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
    end
  spi_shift_engine #(.CLK_DIV(CLK_DIV)) u_eng (
    .clk(clk), .reset(reset), .load(load), .shift_en(shift_en), .load_data(load_data),
    .spi_so(spi_so), .data_clk(data_clk), .spi_si(spi_si), .bit_done(bit_done),
    .byte_done(byte_done), .fall(fall), .rx_byte(rx_byte)
  );
  assign gnt         = gnt_q;
  assign done        = done_q;
  assign chip_select = cs_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
endmodule

// File: tb/tb_spi_flash_arbiter.sv
// tb_spi_flash_arbiter: drives two arbiters (CLK_DIV=2 and CLK_DIV=1) against a behavioural flash
// and a transaction-level arbitration/timing model.
module tb_spi_flash_arbiter;
  localparam int CS_GAP = 4;
  logic        clk = 1'b0, reset = 1'b1, sel = 1'b0, spi_so = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [23:0] addr0 = '0, addr1 = '0;
  logic [7:0]  len0 = 8'd1, len1 = 8'd1;
  logic [1:0]  gnt_a, gnt_b, done_a, done_b, req_a, req_b, gnt, done;
  logic        rdv_a, rdv_b, cs_a, cs_b, sck_a, sck_b, si_a, si_b, rdv, cs, sck, si;
  logic [7:0]  rdd_a, rdd_b, rdd;
  int n_chk = 0, n_err = 0;

  assign req_a = sel ? 2'b00 : req;
  assign req_b = sel ? req : 2'b00;
  assign gnt   = sel ? gnt_b : gnt_a;
  assign done  = sel ? done_b : done_a;
  assign rdv   = sel ? rdv_b : rdv_a;
  assign rdd   = sel ? rdd_b : rdd_a;
  assign cs    = sel ? cs_b : cs_a;
  assign sck   = sel ? sck_b : sck_a;
  assign si    = sel ? si_b : si_a;

  always #5 clk = ~clk;

  spi_flash_arbiter #(.CLK_DIV(2), .CS_GAP(CS_GAP)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .addr0(addr0), .addr1(addr1), .len0(len0), .len1(len1),
    .gnt(gnt_a), .rd_valid(rdv_a), .rd_data(rdd_a), .done(done_a), .chip_select(cs_a),
    .data_clk(sck_a), .spi_si(si_a), .spi_so(spi_so));
  spi_flash_arbiter #(.CLK_DIV(1), .CS_GAP(CS_GAP)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .addr0(addr0), .addr1(addr1), .len0(len0), .len1(len1),
    .gnt(gnt_b), .rd_valid(rdv_b), .rd_data(rdd_b), .done(done_b), .chip_select(cs_b),
    .data_clk(sck_b), .spi_si(si_b), .spi_so(spi_so));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] fbyte(input logic [23:0] a);
    if (a == 24'h123456) return 8'hA5;
    if (a == 24'h123457) return 8'h3C;
    return a[7:0] ^ {a[11:8], a[19:16]} ^ 8'h96;
  endfunction

  // behavioural mode-0 flash: collects command+address, then streams bytes MSB first
  int fbit = 0;
  logic [31:0] fsh = '0;
  always @(negedge cs) begin fbit = 0; fsh = '0; end
  always @(posedge sck) if (!cs) begin
    if (fbit < 32) fsh = {fsh[30:0], si};
    fbit++;
  end
  always @(negedge sck) if (!cs && fbit >= 32) begin
    automatic int o = fbit - 32;
    automatic logic [7:0] b = fbyte(fsh[23:0] + 24'(o / 8));
    spi_so = b[7 - o % 8];
  end

  // transaction-level model of arbitration and framing
  logic active = 0, last = 1, cur_port = 0, exp_p, had_txn = 0, tog_bad = 0;
  logic cs_prev = 1, sck_prev = 0;
  logic [1:0] gnt_prev = 0, req_prev = 0;
  logic [23:0] cur_addr = 0;
  int cur_len = 0, idx = 0, cs_lo = 0, cs_hi = 0, since = 0, grant_cnt = 0, done_tot = 0, rdv_tot = 0, div;
  assign div = sel ? 1 : 2;
  always @(negedge clk) begin
    if (!reset) begin
      active = 0; last = 1; had_txn = 0; gnt_prev = 0; cs_prev = 1; sck_prev = 0; req_prev = req;
    end else begin
      if (gnt != 2'b00 && gnt_prev == 2'b00) begin
        exp_p = (req_prev == 2'b11) ? !last : req_prev[1];
        chk("grant", gnt, exp_p ? 2'b10 : 2'b01);
        last = exp_p; active = 1; cur_port = exp_p; cur_addr = exp_p ? addr1 : addr0;
        cur_len = (exp_p ? len1 : len0) == 8'd0 ? 256 : int'(exp_p ? len1 : len0);
        idx = 0; tog_bad = 0; grant_cnt++;
      end
      if (!cs && cs_prev) begin
        if (had_txn) chk("cs_gap", cs_hi >= CS_GAP + 1, 1);
        cs_lo = 1; since = 0;
      end else if (!cs) begin
        cs_lo++; since++;
        if (sck != sck_prev) begin
          if (since != div) tog_bad = 1;
          since = 0;
        end
      end else if (!cs_prev) begin
        if (active) chk("cs_low_len", cs_lo, 2 * div * (32 + 8 * cur_len));
        cs_hi = 1; had_txn = 1;
      end else cs_hi++;
      if (rdv) begin
        rdv_tot++;
        if (active) begin chk("rd_data", rdd, fbyte(cur_addr + 24'(idx))); idx++; end
        else chk("rd_valid_idle", rdv, 0);
      end
      if (done != 2'b00) begin
        done_tot++;
        if (!active) chk("done_idle", done, 0);
        else begin
          chk("done_port", done, cur_port ? 2'b10 : 2'b01);
          chk("byte_count", idx, cur_len);
          chk("mosi_cmd", fsh[31:24], 8'h03);
          chk("mosi_addr", fsh[23:0], cur_addr);
          chk("sck_period", tog_bad, 0);
          chk("sck_low_at_done", sck, 0);
          active = 0;
        end
      end
      gnt_prev = gnt; cs_prev = cs; sck_prev = sck; req_prev = req;
    end
  end

  task automatic wait_done(output int p, input int lim);
    int n = 0;
    p = -1;
    while (p < 0 && n < lim) begin
      @(negedge clk); n++;
      if (done != 2'b00) p = done[1] ? 1 : 0;
    end
    #1;
    if (p < 0) chk("done_timeout", 0, 1);
  endtask

  task automatic run_req(input logic [1:0] pat, input int lim);
    int p;
    @(posedge clk); #2 req = pat;
    while (req != 2'b00) begin
      wait_done(p, lim);
      @(posedge clk); #2;
      if (p < 0) req = 2'b00;
      else req[p] = 1'b0;
    end
  endtask

  task automatic rand_txn();
    addr0 = 24'($urandom); addr1 = 24'($urandom);
    len0 = 8'($urandom_range(1, 6)); len1 = 8'($urandom_range(1, 6));
    run_req(2'($urandom_range(1, 3)), 1000);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
  endtask

  initial begin
    int p, g0, d0, r0, n;
    #1 reset = 1'b0;
    addr0 = 24'h010203; addr1 = 24'h0A0B0C; req = 2'b11;
    repeat (3) @(negedge clk);
    chk("rst_cs", cs, 1); chk("rst_sck", sck, 0); chk("rst_si", si, 0); chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0); chk("rst_rdv", rdv, 0); chk("rst_rdd", rdd, 0);
    @(posedge clk); #2 reset = 1'b1;
    for (int t = 0; t < 4; t++) begin
      wait_done(p, 2000);
      chk("rr_order", p, t % 2);
    end
    @(posedge clk); #2 req = 2'b00;
    repeat (10) @(posedge clk);

    addr0 = 24'h123456; len0 = 8'd2;
    #2 req = 2'b01;
    @(negedge clk); @(negedge clk);
    chk("grant_latency", gnt, 2'b01); chk("cs_at_grant", cs, 0); chk("si_first", si, 0);
    wait_done(p, 1000);
    chk("single_port", p, 0);
    @(posedge clk); #2 req = 2'b00;
    repeat (10) @(posedge clk);

    addr1 = 24'h00FF00; len1 = 8'd0;
    r0 = rdv_tot; d0 = done_tot;
    run_req(2'b10, 9000);
    chk("wrap_strobes", rdv_tot - r0, 256);
    chk("wrap_dones", done_tot - d0, 1);

    addr0 = 24'h2468AC; len0 = 8'd3;
    @(posedge clk); #2 req = 2'b01;
    repeat (60) @(posedge clk);
    #2 req = 2'b00;
    g0 = grant_cnt;
    wait_done(p, 1000);
    chk("drop_done_port", p, 0);
    repeat (40) @(negedge clk);
    chk("drop_no_regrant", grant_cnt, g0);

    addr0 = 24'($urandom); len0 = 8'd4;
    r0 = rdv_tot;
    @(posedge clk); #2 req = 2'b01;
    n = 0;
    while (rdv_tot == r0 && n < 1000) begin @(negedge clk); n++; end
    chk("rst_wait_data", n < 1000, 1);
    #3 reset = 1'b0; req = 2'b00;
    #1 chk("abort_cs", cs, 1); chk("abort_sck", sck, 0); chk("abort_gnt", gnt, 0);
    d0 = done_tot;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_no_done", done_tot, d0);
    addr0 = 24'h00ABCD; len0 = 8'd2;
    run_req(2'b01, 1000);

    for (int i = 0; i < 12; i++) rand_txn();

    repeat (10) @(posedge clk);
    pulse_reset();
    sel = 1'b1;
    addr0 = 24'h123456; len0 = 8'd2;
    d0 = done_tot;
    run_req(2'b01, 1000);
    chk("div1_done", done_tot - d0, 1);
    for (int i = 0; i < 8; i++) rand_txn();
    repeat (10) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/spi_flash_arbiter.md
# spi_flash_arbiter

Sequences the board SPI configuration flash (read-only, command 0x03) and shares it between two requesters: port 0 is the ROM/boot loader, port 1 is the disk-image streamer. Each granted request becomes one complete flash transaction: chip select, command, 24-bit address, then N data bytes. The block drives the serial pins directly; the SCK output is routed by the top level to the startup primitive's user-CCLK input.

## Interface
Parameters:
- CLK_DIV, 2: SCK half-period in clk cycles (≥1); SCK = clk/(2·CLK_DIV).
- CS_GAP, 4: minimum clk cycles chip_select stays high between transactions (≥1).

Ports:
- clk  in  1  system clock (clock-wizard output); all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  2  per-port request; held high until that port's done pulse.
- addr0, addr1  in  24  flash byte address; sampled at grant.
- len0, len1  in  8  byte count; 0 encodes 256; sampled at grant.
- gnt  out  2  one-hot owner; high from grant through the done cycle.
- rd_valid  out  1  one-cycle strobe per received byte.
- rd_data  out  8  received byte; valid with rd_valid, held until the next strobe.
- done  out  2  one-cycle pulse to the owner after its last byte.
- chip_select  out  1  flash CS, active low.
- data_clk  out  1  SCK, idles low (SPI mode 0).
- spi_si  out  1  MOSI, MSB first.
- spi_so  in  1  MISO.

## Operation
- States: IDLE → CMD (8 bits) → ADDR (24 bits) → DATA (8·N bits) → GAP → IDLE.
- IDLE: if any req bit is high, grant one. Grant latches the owner, its addr and its len, and loads the shifter with 0x03.
- Arbitration is round-robin on a last_owner register (reset value 1). Simultaneous requests go to the port that was not served last, so port 0 wins first after reset. A single request is granted regardless of last_owner.
- CMD/ADDR: shift out {0x03, addr[23:0]} MSB first. spi_si is driven but don't-care during DATA; drive 0.
- DATA:
  - Shift in spi_so MSB first.
  - After each 8th bit, rd_data is loaded and rd_valid pulses.
  - The byte counter decrements. At zero, the block leaves DATA.
- GAP:
  - chip_select goes high and data_clk stays low.
  - done[owner] pulses in the first GAP cycle; gnt clears the cycle after.
  - The block stays in GAP for CS_GAP cycles, then returns to IDLE.
- Dropping req mid-transaction has no effect; the transaction always completes. A request held after its done pulse is a new request.
- Reset values: chip_select=1, data_clk=0, spi_si=0, gnt=0, done=0, rd_valid=0, rd_data=0, state=IDLE, last_owner=1. Reset asserted mid-transaction aborts at once; no done pulse is produced.
- Width rules:
  - Byte counter is 9 bits: len=0 loads 256.
  - Bit counter is 6 bits.
  - Divider counter is ⌈log2(CLK_DIV)⌉ bits, minimum 1.

## Timing
- Grant latency:
  - Request first seen in IDLE at cycle k.
  - gnt, chip_select=0 and spi_si=bit 7 of 0x03 are all registered at cycle k+1.
- SCK edges:
  - First rising edge of data_clk at k+1+CLK_DIV.
  - Edges follow every CLK_DIV cycles after that.
  - spi_si updates together with each falling edge.
  - spi_so is sampled on the clk edge that raises data_clk.
- rd_valid for byte i is asserted the cycle after the rising edge that samples its bit 0.
- The final falling edge of data_clk coincides with chip_select going high and the done pulse. This is CLK_DIV cycles after the last rising edge.
- Total transaction: (32+8N)·2·CLK_DIV cycles from chip_select low to chip_select high. The next chip_select low is no earlier than CS_GAP+1 cycles after that.
- No glitches: data_clk, chip_select and spi_si come straight from flops.

## Structure
- Shared package spi_flash_pkg holds:
  - state enum (IDLE, CMD, ADDR, DATA, GAP);
  - CMD_READ = 8'h03;
  - FLASH_ADDR_W = 24.
- Sub-module spi_shift_engine holds the divider, SCK generation and the 32-bit out / 8-bit in shifter. Interface: load, shift_en, bit_done, byte_done.
- The top-level block keeps the arbiter, the FSM and the counters.

## Test plan
- Single read, CLK_DIV=2:
  - Stimulus: req0, addr0=0x123456, len0=2, flash model returns 0xA5, 0x3C.
  - Expected: MOSI carries 0x03 12 34 56; rd_valid twice with 0xA5 then 0x3C; done[0] once.
  - Expected: chip_select low for exactly 48·4=192 cycles.
- Contention:
  - Stimulus: req=2'b11 held from reset, len=1 each.
  - Expected: port 0 is served first, then port 1, alternating on every following grant; gnt is never 2'b11.
  - Expected: chip_select high for ≥CS_GAP cycles between transactions.
- Length wrap:
  - Stimulus: len1=0 at addr1=0x00FF00.
  - Expected: exactly 256 rd_valid strobes, then a single done[1].
- Request drop:
  - Stimulus: req0 deasserted in the middle of ADDR.
  - Expected: the transaction still completes with done[0]; no new grant follows.
- Reset mid-DATA:
  - Stimulus: reset pulled low between clk edges.
  - Expected: chip_select=1 and data_clk=0 at once; no done pulse.
  - Expected: after release, req0 gives a fresh transaction with command 0x03.
- CLK_DIV=1:
  - Expected: data_clk toggles every cycle; the captured data matches the flash model.
